fp32_mul_round: RTL and testbench

- Post-multiply normalize-and-round stage of the FP32 multiply datapath.
- Consumes the 48-bit significand product from the 24x24 multiplier, the two biased operand exponents and the result sign.
- Produces a packed IEEE-754 single-precision result with status flags.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/fp32_mul_round.sv | 127 ++++++++++++
 tb/tb_fp32_mul_round.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_round.sv
// fp32_mul_round: normalize-and-round back end of the FP32 multiplier.
// Takes the 48-bit significand product, operand exponents and sign, and
// produces a packed single-precision result plus overflow/underflow/inexact.
// Two pipeline stages with valid/ready on both sides and no skid buffer.
module fp32_mul_round #(
    parameter int BIAS = 127
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic        io_in_sign,
    input  logic [7:0]  io_in_exp_a,
    input  logic [7:0]  io_in_exp_b,
    input  logic [47:0] io_in_prod,
    input  logic        io_in_zero,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_result,
    output logic [2:0]  io_out_flags
);

    // Round-to-nearest-even increment decision from guard/sticky/lsb.
    function automatic logic round_up(input logic g, input logic st, input logic lsb);
        return g && (st || lsb);
    endfunction

    // Stage-1 registers (normalized fields)
    logic               s1_valid_q, s1_valid_d;
    logic               s1_sign_q,  s1_sign_d;
    logic               s1_zero_q,  s1_zero_d;
    logic signed [9:0]  s1_exp_q,   s1_exp_d;
    logic [22:0]        s1_mant_q,  s1_mant_d;
    logic               s1_g_q,     s1_g_d;
    logic               s1_st_q,    s1_st_d;

    // Stage-2 registers (packed result, drive the outputs directly)
    logic               s2_valid_q, s2_valid_d;
    logic [31:0]        s2_result_q, s2_result_d;
    logic [2:0]         s2_flags_q,  s2_flags_d;

    logic               s1_adv, s2_adv;
    logic signed [9:0]  e_sum;
    logic [23:0]        mant_r;
    logic signed [9:0]  e_r;

    // Pipeline advance: a stage moves when it is empty or its consumer moves.
    always_comb begin
        s2_adv      = !s2_valid_q || io_out_ready;
        s1_adv      = !s1_valid_q || s2_adv;
        io_in_ready = s1_adv;
    end

    // Stage 1: unbias exponent sum and normalize the product to 1.xxx form.
    always_comb begin
        e_sum = signed'({2'b00, io_in_exp_a}) + signed'({2'b00, io_in_exp_b})
                - signed'(10'(BIAS));
        s1_sign_d = io_in_sign;
        s1_zero_d = io_in_zero;
        s1_exp_d  = e_sum;
        s1_mant_d = io_in_prod[45:23];
        s1_g_d    = io_in_prod[22];
        s1_st_d   = |io_in_prod[21:0];
        if (io_in_prod[47]) begin
            s1_exp_d  = e_sum + 10'sd1;
            s1_mant_d = io_in_prod[46:24];
            s1_g_d    = io_in_prod[23];
            s1_st_d   = |io_in_prod[22:0];
        end
        s1_valid_d = s1_adv ? io_in_valid : s1_valid_q;
    end

    // Stage 2: round, fold the rounding carry into the exponent, then pack
    // with exception priority zero > overflow > underflow > normal.
    always_comb begin
        mant_r = {1'b0, s1_mant_q} + {23'd0, round_up(s1_g_q, s1_st_q, s1_mant_q[0])};
        e_r    = s1_exp_q + (mant_r[23] ? 10'sd1 : 10'sd0);
        if (s1_zero_q) begin
            s2_result_d = {s1_sign_q, 31'd0};
            s2_flags_d  = 3'b000;
        end else if (e_r >= 10'sd255) begin
            s2_result_d = {s1_sign_q, 8'hFF, 23'd0};
            s2_flags_d  = 3'b101;
        end else if (e_r <= 10'sd0) begin
            s2_result_d = {s1_sign_q, 31'd0};
            s2_flags_d  = 3'b011;
        end else begin
            s2_result_d = {s1_sign_q, e_r[7:0], mant_r[22:0]};
            s2_flags_d  = {2'b00, s1_g_q | s1_st_q};
        end
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end

    // Control state and output registers; reset discards everything in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= 32'd0;
            s2_flags_q  <= 3'b000;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s2_adv && s1_valid_q) begin
                s2_result_q <= s2_result_d;
                s2_flags_q  <= s2_flags_d;
            end
        end
    end

    // Stage-1 datapath registers; qualified by s1_valid_q so no reset needed.
    always_ff @(posedge clock) begin
        if (s1_adv && io_in_valid) begin
            s1_sign_q <= s1_sign_d;
            s1_zero_q <= s1_zero_d;
            s1_exp_q  <= s1_exp_d;
            s1_mant_q <= s1_mant_d;
            s1_g_q    <= s1_g_d;
            s1_st_q   <= s1_st_d;
        end
    end

    assign io_out_valid  = s2_valid_q;
    assign io_out_result = s2_result_q;
    assign io_out_flags  = s2_flags_q;

endmodule

// File: tb/tb_fp32_mul_round.sv
// Directed bench for fp32_mul_round: hand-computed vectors, latency,
// backpressure ordering and asynchronous reset behaviour.
module tb_fp32_mul_round;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic        io_in_sign;
    logic [7:0]  io_in_exp_a;
    logic [7:0]  io_in_exp_b;
    logic [47:0] io_in_prod;
    logic        io_in_zero;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_result;
    logic [2:0]  io_out_flags;

    int n_tests = 0;
    int n_fail  = 0;

    fp32_mul_round #(.BIAS(127)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_sign   (io_in_sign),
        .io_in_exp_a  (io_in_exp_a),
        .io_in_exp_b  (io_in_exp_b),
        .io_in_prod   (io_in_prod),
        .io_in_zero   (io_in_zero),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_result(io_out_result),
        .io_out_flags (io_out_flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [47:0] p, input logic z);
        io_in_valid = 1'b1;
        io_in_sign  = s;
        io_in_exp_a = ea;
        io_in_exp_b = eb;
        io_in_prod  = p;
        io_in_zero  = z;
    endtask

    // One operation through an empty pipeline with io_out_ready high.
    task automatic do_op(input string tag, input logic s, input logic [7:0] ea,
                         input logic [7:0] eb, input logic [47:0] p, input logic z,
                         input logic [31:0] exp_res, input logic [2:0] exp_flg);
        drive(s, ea, eb, p, z);
        check({tag, " in_ready"}, {31'd0, io_in_ready}, 32'd1);
        step();
        io_in_valid = 1'b0;
        check({tag, " valid@1"}, {31'd0, io_out_valid}, 32'd0);
        step();
        check({tag, " valid@2"}, {31'd0, io_out_valid}, 32'd1);
        check({tag, " result"}, io_out_result, exp_res);
        check({tag, " flags"}, {29'd0, io_out_flags}, {29'd0, exp_flg});
        step();
    endtask

    initial begin
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_sign   = 1'b0;
        io_in_exp_a  = 8'd0;
        io_in_exp_b  = 8'd0;
        io_in_prod   = 48'd0;
        io_in_zero   = 1'b0;
        io_out_ready = 1'b1;
        #1;
        check("rst valid", {31'd0, io_out_valid}, 32'd0);
        check("rst result", io_out_result, 32'd0);
        check("rst flags", {29'd0, io_out_flags}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Main function and boundaries
        do_op("one",      1'b0, 8'd127, 8'd127, 48'h400000000000, 1'b0, 32'h3F800000, 3'b000);
        do_op("1.5sq",    1'b0, 8'd127, 8'd127, 48'h900000000000, 1'b0, 32'h40100000, 3'b000);
        do_op("tie_even", 1'b0, 8'd127, 8'd127, 48'h400000400000, 1'b0, 32'h3F800000, 3'b001);
        do_op("tie_odd",  1'b0, 8'd127, 8'd127, 48'h400000C00000, 1'b0, 32'h3F800002, 3'b001);
        do_op("carry",    1'b0, 8'd127, 8'd127, 48'h7FFFFFFFFFFF, 1'b0, 32'h40000000, 3'b001);
        do_op("ovf",      1'b1, 8'd254, 8'd254, 48'h400000000000, 1'b0, 32'hFF800000, 3'b101);
        do_op("unf",      1'b0, 8'd1,   8'd1,   48'h400000000000, 1'b0, 32'h00000000, 3'b011);
        do_op("zero",     1'b1, 8'd127, 8'd127, 48'h400000000000, 1'b1, 32'h80000000, 3'b000);
        do_op("ovf_rnd",  1'b0, 8'd254, 8'd127, 48'h7FFFFFFFFFFF, 1'b0, 32'h7F800000, 3'b101);
        do_op("e_zero",   1'b0, 8'd64,  8'd63,  48'h400000000000, 1'b0, 32'h00000000, 3'b011);
        do_op("e_one",    1'b1, 8'd64,  8'd64,  48'h400000000000, 1'b0, 32'h80800000, 3'b000);
        do_op("sticky",   1'b0, 8'd127, 8'd127, 48'h400000200001, 1'b0, 32'h3F800000, 3'b001);

        // Backpressure: three back-to-back offers with downstream stalled
        io_out_ready = 1'b0;
        drive(1'b0, 8'd127, 8'd127, 48'h400000000000, 1'b0);
        check("bp rdyA", {31'd0, io_in_ready}, 32'd1);
        step();
        drive(1'b0, 8'd127, 8'd127, 48'h900000000000, 1'b0);
        check("bp rdyB", {31'd0, io_in_ready}, 32'd1);
        step();
        drive(1'b0, 8'd127, 8'd127, 48'h400000C00000, 1'b0);
        check("bp rdyC0", {31'd0, io_in_ready}, 32'd0);
        check("bp validA", {31'd0, io_out_valid}, 32'd1);
        check("bp resA", io_out_result, 32'h3F800000);
        step();
        check("bp rdyC1", {31'd0, io_in_ready}, 32'd0);
        check("bp holdA", io_out_result, 32'h3F800000);
        check("bp holdv", {31'd0, io_out_valid}, 32'd1);
        io_out_ready = 1'b1;
        #1;
        check("bp rdyC2", {31'd0, io_in_ready}, 32'd1);
        step();
        io_in_valid = 1'b0;
        check("bp validB", {31'd0, io_out_valid}, 32'd1);
        check("bp resB", io_out_result, 32'h40100000);
        step();
        check("bp validC", {31'd0, io_out_valid}, 32'd1);
        check("bp resC", io_out_result, 32'h3F800002);
        check("bp flgC", {29'd0, io_out_flags}, 32'd1);
        step();
        check("bp drained", {31'd0, io_out_valid}, 32'd0);

        // Asynchronous reset with both stages full
        io_out_ready = 1'b0;
        drive(1'b1, 8'd254, 8'd254, 48'h400000000000, 1'b0);
        step();
        drive(1'b0, 8'd127, 8'd127, 48'h900000000000, 1'b0);
        step();
        io_in_valid = 1'b0;
        check("pre-rst valid", {31'd0, io_out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async rst valid", {31'd0, io_out_valid}, 32'd0);
        check("async rst result", io_out_result, 32'd0);
        check("async rst flags", {29'd0, io_out_flags}, 32'd0);
        step();
        reset = 1'b0;
        io_out_ready = 1'b1;
        #1;
        check("post-rst valid", {31'd0, io_out_valid}, 32'd0);
        do_op("post_rst", 1'b0, 8'd127, 8'd127, 48'h400000C00000, 1'b0, 32'h3F800002, 3'b001);
        check("post-rst empty", {31'd0, io_out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
